// File: rtl/triangle_monitor_if.sv
//==============================================================================
// Module   : triangle_monitor_if
// Purpose  : Sample/control and status bundle between a triangle source and its monitor.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

interface triangle_monitor_if #(
    parameter int N        = 8,
    parameter int PERIOD_W = 20
);
    logic                ena_i;
    logic [N-1:0]        in_i;
    logic                clear_err_i;
    logic                dir_o;
    logic                locked_o;
    logic                peak_o;
    logic                trough_o;
    logic                mismatch_o;
    logic                err_o;
    logic [PERIOD_W-1:0] period_o;
    logic                period_valid_o;

    modport master (
        output ena_i, in_i, clear_err_i,
        input  dir_o, locked_o, peak_o, trough_o, mismatch_o, err_o, period_o, period_valid_o
    );

    modport slave (
        input  ena_i, in_i, clear_err_i,
        output dir_o, locked_o, peak_o, trough_o, mismatch_o, err_o, period_o, period_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/triangle_monitor.sv
//==============================================================================
// Module   : triangle_monitor
// Purpose  : Locks to a 0..M..0 triangle stream, flags turns, errors and period.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module triangle_monitor #(
    parameter int N        = 8,
    parameter int PERIOD_W = 20
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    triangle_monitor_if.slave bus
);

    localparam logic [N-1:0]        MAXV    = '1;
    localparam logic [N-1:0]        ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
    localparam logic [PERIOD_W-1:0] CNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_ACQUIRE    = 2'd0;
    localparam logic [1:0] S_TRACK_UP   = 2'd1;
    localparam logic [1:0] S_TRACK_DOWN = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [N-1:0]        prev_q, prev_d;
    logic                first_seen_q, first_seen_d;
    logic                dir_q, dir_d;
    logic                peak_q, peak_d;
    logic                trough_q, trough_d;
    logic                mismatch_q, mismatch_d;
    logic                err_q, err_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                pv_q, pv_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                have_trough_q, have_trough_d;

    logic                is_inc;
    logic                is_dec;
    logic [PERIOD_W-1:0] cnt_inc;

    assign is_inc  = (prev_q != MAXV) && (bus.in_i == prev_q + ONE);
    assign is_dec  = (prev_q != '0)   && (bus.in_i == prev_q - ONE);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    // A lock step that lands on an extreme turns immediately, so TRACK_UP never holds prev==M.
    always_comb begin
        state_d = state_q;
        if (bus.ena_i) begin
            case (state_q)
                S_ACQUIRE: begin
                    if (first_seen_q) begin
                        if (is_inc) begin
                            state_d = (bus.in_i == MAXV) ? S_TRACK_DOWN : S_TRACK_UP;
                        end else if (is_dec) begin
                            state_d = (bus.in_i == '0) ? S_TRACK_UP : S_TRACK_DOWN;
                        end
                    end
                end
                S_TRACK_UP: begin
                    if (!is_inc) begin
                        state_d = S_ACQUIRE;
                    end else if (bus.in_i == MAXV) begin
                        state_d = S_TRACK_DOWN;
                    end
                end
                S_TRACK_DOWN: begin
                    if (!is_dec) begin
                        state_d = S_ACQUIRE;
                    end else if (bus.in_i == '0) begin
                        state_d = S_TRACK_UP;
                    end
                end
                default: state_d = S_ACQUIRE;
            endcase
        end
    end

    always_comb begin
        prev_d        = prev_q;
        first_seen_d  = first_seen_q;
        dir_d         = dir_q;
        peak_d        = 1'b0;
        trough_d      = 1'b0;
        mismatch_d    = 1'b0;
        err_d         = err_q;
        period_d      = period_q;
        pv_d          = 1'b0;
        cnt_d         = cnt_q;
        have_trough_d = have_trough_q;

        if (bus.clear_err_i) begin
            err_d = 1'b0;
        end

        if (bus.ena_i) begin
            prev_d = bus.in_i;
            case (state_q)
                S_ACQUIRE: begin
                    first_seen_d = 1'b1;
                    if (state_d != S_ACQUIRE) begin
                        cnt_d         = '0;
                        have_trough_d = 1'b0;
                        dir_d         = (state_d == S_TRACK_DOWN);
                    end
                end
                S_TRACK_UP, S_TRACK_DOWN: begin
                    if (state_d == S_ACQUIRE) begin
                        mismatch_d = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (state_d != state_q) begin
                            if (state_q == S_TRACK_UP) begin
                                peak_d = 1'b1;
                                dir_d  = 1'b1;
                            end else begin
                                trough_d      = 1'b1;
                                dir_d         = 1'b0;
                                cnt_d         = '0;
                                have_trough_d = 1'b1;
                                if (have_trough_q) begin
                                    period_d = cnt_inc;
                                    pv_d     = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q        <= '0;
            first_seen_q  <= 1'b0;
            dir_q         <= 1'b0;
            peak_q        <= 1'b0;
            trough_q      <= 1'b0;
            mismatch_q    <= 1'b0;
            err_q         <= 1'b0;
            period_q      <= '0;
            pv_q          <= 1'b0;
            cnt_q         <= '0;
            have_trough_q <= 1'b0;
        end else begin
            prev_q        <= prev_d;
            first_seen_q  <= first_seen_d;
            dir_q         <= dir_d;
            peak_q        <= peak_d;
            trough_q      <= trough_d;
            mismatch_q    <= mismatch_d;
            err_q         <= err_d;
            period_q      <= period_d;
            pv_q          <= pv_d;
            cnt_q         <= cnt_d;
            have_trough_q <= have_trough_d;
        end
    end

    assign bus.dir_o          = dir_q;
    assign bus.locked_o       = (state_q != S_ACQUIRE);
    assign bus.peak_o         = peak_q;
    assign bus.trough_o       = trough_q;
    assign bus.mismatch_o     = mismatch_q;
    assign bus.err_o          = err_q;
    assign bus.period_o       = period_q;
    assign bus.period_valid_o = pv_q;

endmodule

`default_nettype wire

// File: tb/tb_triangle_monitor.sv
//==============================================================================
// Module   : tb_triangle_monitor
// Purpose  : Self-checking bench for triangle_monitor (N=4) with reference model.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_triangle_monitor;
    localparam int N    = 4;
    localparam int PW   = 20;
    localparam int M    = (1 << N) - 1;
    localparam int CMAX = (1 << PW) - 1;
    localparam int VW   = PW + 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    triangle_monitor_if #(.N(N), .PERIOD_W(PW)) bus ();
    triangle_monitor #(.N(N), .PERIOD_W(PW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int ncheck = 0;
    int npass  = 0;

    // Reference model: step is the current slope (+1/-1), 0 while unlocked.
    int m_step, m_have, m_prev, m_dir, m_err, m_cnt, m_have_tr, m_period;
    bit e_peak, e_trough, e_mm, e_pv;

    typedef struct {
        bit ena; int s; bit clr;
        bit lk; bit dr; bit pk; bit tr; bit mm; bit er;
    } vec_t;
    vec_t tbl[22];

    function automatic vec_t mk(bit e, int s, bit c, bit lk, bit dr, bit pk, bit tr, bit mm, bit er);
        vec_t v;
        v.ena = e; v.s = s; v.clr = c;
        v.lk = lk; v.dr = dr; v.pk = pk; v.tr = tr; v.mm = mm; v.er = er;
        return v;
    endfunction

    function automatic logic [VW-1:0] got_vec();
        return {bus.dir_o, bus.locked_o, bus.peak_o, bus.trough_o, bus.mismatch_o,
                bus.err_o, bus.period_valid_o, bus.period_o};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [PW-1:0] p;
        p = m_period[PW-1:0];
        return {m_dir != 0, m_step != 0, e_peak, e_trough, e_mm, m_err != 0, e_pv, p};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        ncheck++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic model_reset();
        m_step = 0; m_have = 0; m_prev = 0; m_dir = 0; m_err = 0;
        m_cnt = 0; m_have_tr = 0; m_period = 0;
        e_peak = 0; e_trough = 0; e_mm = 0; e_pv = 0;
    endtask

    task automatic model_step(input bit e, input int s, input bit c);
        e_peak = 0; e_trough = 0; e_mm = 0; e_pv = 0;
        if (c) m_err = 0;
        if (e) begin
            if (m_step == 0) begin
                if (m_have != 0) begin
                    if (s == m_prev + 1) m_step = 1;
                    else if (s == m_prev - 1) m_step = -1;
                    if (m_step != 0) begin
                        m_cnt = 0; m_have_tr = 0;
                        if (m_step == 1 && s == M) m_step = -1;
                        else if (m_step == -1 && s == 0) m_step = 1;
                        m_dir = (m_step == -1);
                    end
                end
                m_have = 1;
            end else if (s == m_prev + m_step) begin
                m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                if (m_step == 1 && s == M) begin
                    e_peak = 1; m_step = -1; m_dir = 1;
                end else if (m_step == -1 && s == 0) begin
                    e_trough = 1; m_step = 1; m_dir = 0;
                    if (m_have_tr != 0) begin m_period = m_cnt; e_pv = 1; end
                    m_cnt = 0; m_have_tr = 1;
                end
            end else begin
                e_mm = 1; m_err = 1; m_step = 0;
            end
            m_prev = s;
        end
    endtask

    task automatic step(input bit e, input int s, input bit c);
        @(negedge clk);
        bus.ena_i = e; bus.in_i = s[N-1:0]; bus.clear_err_i = c;
        @(posedge clk);
        model_step(e, s, c);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; bus.ena_i = 1'b0; bus.in_i = '0; bus.clear_err_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("reset_state", got_vec(), '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int stream[$];
    int npk, ntr, npv, nmm;

    task automatic count_pulses();
        npk += bus.peak_o; ntr += bus.trough_o; npv += bus.period_valid_o; nmm += bus.mismatch_o;
    endtask

    initial begin
        rst_n = 1'b1; bus.ena_i = 1'b0; bus.in_i = '0; bus.clear_err_i = 1'b0;
        model_reset();
        for (int v = 0; v <= M; v++) stream.push_back(v);
        for (int v = M - 1; v >= 0; v--) stream.push_back(v);
        for (int v = 1; v <= M; v++) stream.push_back(v);
        for (int v = M - 1; v >= 0; v--) stream.push_back(v);

        // Clean stream, ena always high
        do_reset();
        npk = 0; ntr = 0; npv = 0; nmm = 0;
        foreach (stream[i]) begin
            step(1'b1, stream[i], 1'b0);
            check("clean_model", got_vec(), exp_vec());
            if (i == 0) check("lock_after_1st", {{(VW-1){1'b0}}, bus.locked_o}, '0);
            if (i == 1) check("lock_after_2nd", {{(VW-1){1'b0}}, bus.locked_o}, 1);
            count_pulses();
        end
        check("clean_peaks",   VW'(npk), VW'(2));
        check("clean_troughs", VW'(ntr), VW'(2));
        check("clean_pv",      VW'(npv), VW'(1));
        check("clean_mm",      VW'(nmm), VW'(0));
        check("clean_period",  VW'(bus.period_o), VW'(30));
        check("clean_err",     VW'(bus.err_o), VW'(0));

        // Same stream stretched by idle cycles carrying junk samples
        do_reset();
        npk = 0; ntr = 0; npv = 0; nmm = 0;
        foreach (stream[i]) begin
            step(1'b1, stream[i], 1'b0);
            check("stretch_model", got_vec(), exp_vec());
            count_pulses();
            step(1'b0, int'($urandom_range(0, M)), 1'b0);
            check("stretch_idle", got_vec(), exp_vec());
            count_pulses();
        end
        check("stretch_peaks",   VW'(npk), VW'(2));
        check("stretch_troughs", VW'(ntr), VW'(2));
        check("stretch_pv",      VW'(npv), VW'(1));
        check("stretch_mm",      VW'(nmm), VW'(0));
        check("stretch_period",  VW'(bus.period_o), VW'(30));

        // Mismatch, relock, wrap, err clear priority, lock-down and trough
        tbl[0]  = mk(1, 3, 0,  0,0,0,0,0,0);
        tbl[1]  = mk(1, 4, 0,  1,0,0,0,0,0);
        tbl[2]  = mk(1, 5, 0,  1,0,0,0,0,0);
        tbl[3]  = mk(1, 7, 0,  0,0,0,0,1,1);
        tbl[4]  = mk(1, 8, 0,  1,0,0,0,0,1);
        tbl[5]  = mk(0, 0, 1,  1,0,0,0,0,0);
        for (int k = 0; k < 6; k++) tbl[6+k] = mk(1, 9+k, 0, 1,0,0,0,0,0);
        tbl[12] = mk(1, 15, 0, 1,1,1,0,0,0);
        tbl[13] = mk(1, 0, 0,  0,1,0,0,1,1);
        tbl[14] = mk(1, 1, 0,  1,0,0,0,0,1);
        tbl[15] = mk(1, 3, 1,  0,0,0,0,1,1);
        tbl[16] = mk(0, 9, 1,  0,0,0,0,0,0);
        tbl[17] = mk(0, 5, 0,  0,0,0,0,0,0);
        tbl[18] = mk(1, 2, 0,  1,1,0,0,0,0);
        tbl[19] = mk(1, 1, 0,  1,1,0,0,0,0);
        tbl[20] = mk(1, 0, 0,  1,0,0,1,0,0);
        tbl[21] = mk(1, 1, 0,  1,0,0,0,0,0);
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].ena, tbl[i].s, tbl[i].clr);
            check($sformatf("table_%0d", i),
                  VW'({bus.locked_o, bus.dir_o, bus.peak_o, bus.trough_o, bus.mismatch_o, bus.err_o}),
                  VW'({tbl[i].lk, tbl[i].dr, tbl[i].pk, tbl[i].tr, tbl[i].mm, tbl[i].er}));
            check($sformatf("table_model_%0d", i), got_vec(), exp_vec());
        end

        // Asynchronous reset in the middle of a descent
        do_reset();
        for (int v = 0; v <= M; v++) step(1'b1, v, 1'b0);
        for (int v = M - 1; v >= 10; v--) step(1'b1, v, 1'b0);
        check("pre_async_locked", VW'(bus.locked_o), VW'(1));
        #2 rst_n = 1'b0;
        #1 check("async_reset", got_vec(), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5, 1'b0);
        check("post_rst_first", got_vec(), exp_vec());
        check("post_rst_unlocked", VW'(bus.locked_o), VW'(0));
        step(1'b1, 6, 1'b0);
        check("post_rst_relock", VW'({bus.locked_o, bus.dir_o}), VW'(2'b10));

        // Randomised triangle with glitches, gaps and clears
        do_reset();
        begin
            int gv, gup, s;
            bit e, c;
            gv = 0; gup = 1;
            for (int k = 0; k < 3000; k++) begin
                e = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 19) == 0);
                s = int'($urandom_range(0, M));
                if (e && $urandom_range(0, 24) != 0) begin
                    if (gup != 0) begin
                        if (gv == M) begin gup = 0; gv = gv - 1; end
                        else gv = gv + 1;
                    end else if (gv == 0) begin
                        gup = 1; gv = 1;
                    end else gv = gv - 1;
                    s = gv;
                end
                step(e, s, c);
                check("random_model", got_vec(), exp_vec());
            end
        end

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
